esteira_simulador: RTL
======================

ESTEIRA_SIMULADOR -- requirements
Module: esteira_simulador

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: number of CLK cycles per movement/fill tick (must be at least 1).
REQ-002 SHALL have parameter POS_ENCHIMENTO, default 8: bottle position of the filling station.
REQ-003 SHALL have parameter POS_CQ, default 16: bottle position of the quality-control station.
REQ-004 SHALL have parameter POS_LACRE, default 24: bottle position of the sealing/counting station.
REQ-005 SHALL have parameter POS_FIM, default 31: exit position, with POS_ENCHIMENTO < POS_CQ < POS_LACRE < POS_FIM ≤ 255.
REQ-006 SHALL have parameter NIVEL_CHEIO, default 6: fill ticks needed for a full bottle (1..15).
REQ-007 SHALL have port CLK, input, 1 bit: single system clock.
REQ-008 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port MOTOR, input, 1 bit: conveyor motor command from the controller.
REQ-010 SHALL have port VALVULA_ENCHIMENTO, input, 1 bit: fill valve command.
REQ-011 SHALL have port ATUADOR_VEDACAO, input, 1 bit: cork actuator command.
REQ-012 SHALL have port NOVA_GARRAFA, input, 1 bit: rising edge loads an empty bottle at position 0.
REQ-013 SHALL have port SENSOR_POS_ENCHIMENTO, output, 1 bit: bottle present at the filling station.
REQ-014 SHALL have port SENSOR_POS_CQ, output, 1 bit: bottle present at the quality-control station.
REQ-015 SHALL have port SENSOR_POS_LACRE, output, 1 bit: bottle present at the sealing station.
REQ-016 SHALL have port SENSOR_GARRAFA_CHEIA, output, 1 bit: current bottle level is at least NIVEL_CHEIO.
REQ-017 SHALL have port GARRAFA_VEDADA, output, 1 bit: current bottle is corked.
REQ-018 SHALL have port GARRAFA_PRESENTE, output, 1 bit: a bottle is on the belt.
REQ-019 SHALL have port POSICAO, output, 8 bits: current bottle position.
REQ-020 SHALL have port GARRAFAS_SAIDA, output, 8 bits: number of bottles exited.
REQ-021 SHALL have port ERRO_DERRAMAMENTO, output, 1 bit: sticky spill/overfill flag.

Function
REQ-022 SHALL implement a prescaler counting 0..TICK_DIV-1; a tick SHALL be the cycle in which the prescaler equals TICK_DIV-1; the prescaler SHALL free-run.
REQ-023 SHALL implement the FSM states VAZIA, TRANSITO and SAIDA; the reset state SHALL be VAZIA.
REQ-024 VAZIA SHALL go to TRANSITO on a registered rising edge of NOVA_GARRAFA, clearing POSICAO, the fill level and GARRAFA_VEDADA.
REQ-025 NOVA_GARRAFA edges SHALL be ignored in TRANSITO and SAIDA.
REQ-026 In TRANSITO, POSICAO SHALL increment by 1 on each tick while MOTOR=1 and SHALL hold while MOTOR=0.
REQ-027 When POSICAO reaches POS_FIM, the FSM SHALL enter SAIDA; SAIDA SHALL last exactly one cycle, increment GARRAFAS_SAIDA (wrapping 255->0), and return to VAZIA.
REQ-028 Station sensors SHALL be Moore outputs: asserted while in TRANSITO and POSICAO equals the station parameter, with no added latency beyond the POSICAO register.
REQ-029 Fill level (4 bits) SHALL increment on each tick while VALVULA_ENCHIMENTO=1 and POSICAO=POS_ENCHIMENTO in TRANSITO, saturating at 15.
REQ-030 SENSOR_GARRAFA_CHEIA SHALL be 1 when the fill level is at least NIVEL_CHEIO and a bottle is present.
REQ-031 ATUADOR_VEDACAO=1 at POS_ENCHIMENTO with the bottle full SHALL set GARRAFA_VEDADA, which SHALL stay set until the next load.
REQ-032 When MOTOR=1 and VALVULA=1 on the same tick, the position SHALL advance and the fill level SHALL not increment (the spill is evaluated per REQ-036).
REQ-033 GARRAFA_PRESENTE SHALL equal (state != VAZIA).

Reset
REQ-034 RESET=0 SHALL asynchronously force state VAZIA, prescaler 0, POSICAO 0, fill level 0, GARRAFAS_SAIDA 0, and all 1-bit outputs 0, including mid-transit and mid-fill.
REQ-035 Release of reset SHALL take effect on the next CLK rising edge, and the NOVA_GARRAFA edge detector SHALL be reset to 0.

Configuration
REQ-036 With macro ESTEIRA_SIM_ERROS_EN defined, ERRO_DERRAMAMENTO SHALL set on any tick where VALVULA=1 and either no bottle is at POS_ENCHIMENTO, MOTOR=1, or the level is at least NIVEL_CHEIO; it SHALL clear only on reset.
REQ-037 Without ESTEIRA_SIM_ERROS_EN, ERRO_DERRAMAMENTO SHALL be constant 0 and no error logic SHALL be synthesized.

Verification
REQ-038 The bench SHALL cover: defaults, NOVA_GARRAFA pulse, MOTOR=1 for 8 ticks -> SENSOR_POS_ENCHIMENTO=1 at POSICAO=8 and 0 at POSICAO=9.
REQ-039 The bench SHALL cover: at POSICAO=8, MOTOR=0, VALVULA=1 for 6 ticks -> SENSOR_GARRAFA_CHEIA=1 after the 6th tick; then ATUADOR_VEDACAO=1 -> GARRAFA_VEDADA=1.
REQ-040 The bench SHALL cover: MOTOR=1 continuously from load -> SENSOR_POS_CQ at 16, SENSOR_POS_LACRE at 24, a one-cycle SAIDA at 31, GARRAFAS_SAIDA 0->1, GARRAFA_PRESENTE=0.
REQ-041 The bench SHALL cover: a second NOVA_GARRAFA pulse at POSICAO=12 -> ignored, with POSICAO continuing to 13.
REQ-042 The bench SHALL cover: RESET=0 asynchronously at POSICAO=20 -> all outputs 0 before the next CLK edge.
REQ-043 The bench SHALL cover: with ESTEIRA_SIM_ERROS_EN defined, VALVULA=1 at POSICAO=3 -> ERRO_DERRAMAMENTO=1, held until reset; without the macro, the same stimulus -> ERRO_DERRAMAMENTO=0.

Source files
------------

// File: rtl/esteira_simulador.sv
// esteira_simulador: single-bottle conveyor plant model with fill, cork and exit-count stations.
// Optional spill detection on ERRO_DERRAMAMENTO is enabled by defining ESTEIRA_SIM_ERROS_EN.
module esteira_simulador #(
    parameter int TICK_DIV       = 4,
    parameter int POS_ENCHIMENTO = 8,
    parameter int POS_CQ         = 16,
    parameter int POS_LACRE      = 24,
    parameter int POS_FIM        = 31,
    parameter int NIVEL_CHEIO    = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MOTOR,
    input  logic       VALVULA_ENCHIMENTO,
    input  logic       ATUADOR_VEDACAO,
    input  logic       NOVA_GARRAFA,
    output logic       SENSOR_POS_ENCHIMENTO,
    output logic       SENSOR_POS_CQ,
    output logic       SENSOR_POS_LACRE,
    output logic       SENSOR_GARRAFA_CHEIA,
    output logic       GARRAFA_VEDADA,
    output logic       GARRAFA_PRESENTE,
    output logic [7:0] POSICAO,
    output logic [7:0] GARRAFAS_SAIDA,
    output logic       ERRO_DERRAMAMENTO
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {VAZIA, TRANSITO, SAIDA} estado_t;

    estado_t       estado;
    logic [PW-1:0] presc;
    logic [3:0]    nivel;
    logic          nova_q;
    logic          tick, borda, em_trans, na_ench, cheio;

    assign tick     = presc == PW'(TICK_DIV - 1);
    assign borda    = NOVA_GARRAFA & ~nova_q;
    assign em_trans = estado == TRANSITO;
    assign na_ench  = em_trans && POSICAO == 8'(POS_ENCHIMENTO);
    assign cheio    = nivel >= 4'(NIVEL_CHEIO);

    assign SENSOR_POS_ENCHIMENTO = na_ench;
    assign SENSOR_POS_CQ         = em_trans && POSICAO == 8'(POS_CQ);
    assign SENSOR_POS_LACRE      = em_trans && POSICAO == 8'(POS_LACRE);
    assign SENSOR_GARRAFA_CHEIA  = cheio && estado != VAZIA;
    assign GARRAFA_PRESENTE      = estado != VAZIA;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            estado         <= VAZIA;
            presc          <= '0;
            nivel          <= '0;
            nova_q         <= 1'b0;
            POSICAO        <= '0;
            GARRAFAS_SAIDA <= '0;
            GARRAFA_VEDADA <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            nova_q <= NOVA_GARRAFA;
            case (estado)
                VAZIA: if (borda) begin
                    estado         <= TRANSITO;
                    POSICAO        <= '0;
                    nivel          <= '0;
                    GARRAFA_VEDADA <= 1'b0;
                end
                TRANSITO: begin
                    if (ATUADOR_VEDACAO && na_ench && cheio)
                        GARRAFA_VEDADA <= 1'b1;
                    // a moving belt spills instead of filling
                    if (tick && VALVULA_ENCHIMENTO && na_ench && !MOTOR && nivel != 4'hf)
                        nivel <= nivel + 1'b1;
                    if (tick && MOTOR) begin
                        POSICAO <= POSICAO + 1'b1;
                        if (POSICAO == 8'(POS_FIM - 1))
                            estado <= SAIDA;
                    end
                end
                SAIDA: begin
                    GARRAFAS_SAIDA <= GARRAFAS_SAIDA + 1'b1;
                    estado         <= VAZIA;
                end
                default: estado <= VAZIA;
            endcase
        end
    end

`ifdef ESTEIRA_SIM_ERROS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ERRO_DERRAMAMENTO <= 1'b0;
        else if (tick && VALVULA_ENCHIMENTO && (!na_ench || MOTOR || cheio))
            ERRO_DERRAMAMENTO <= 1'b1;
    end
`else
    assign ERRO_DERRAMAMENTO = 1'b0;
`endif
endmodule
